// File: rtl/mod_5_fsm.sv
// Free-running modulo-5 Moore counter (S0..S4 -> q = 0..4), up or down per DIR.
// Optional build macro MOD5_FSM_ONEHOT_EN: one-hot state with registered binary encode and a state checker.
`ifdef MOD5_FSM_ONEHOT_EN
module mod_5_fsm_chk (
    input logic       clk,
    input logic       rst,
    input logic [4:0] state
);

    // Flag any non-one-hot state seen outside reset.
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot(state))
            else $error("mod_5_fsm: state %b is not one-hot", state);
        end
    end

endmodule
`endif

module mod_5_fsm #(
    parameter int RST_STATE = 0,
    parameter bit DIR       = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] q
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    // Out-of-range reset indices fall back to S0.
    localparam logic [2:0] RST_IDX = ((RST_STATE >= 0) && (RST_STATE <= 4)) ? 3'(RST_STATE) : 3'd0;

`ifdef MOD5_FSM_ONEHOT_EN
    localparam logic [4:0] OH_S0 = 5'b00001;
    localparam logic [4:0] OH_S1 = 5'b00010;
    localparam logic [4:0] OH_S2 = 5'b00100;
    localparam logic [4:0] OH_S3 = 5'b01000;
    localparam logic [4:0] OH_S4 = 5'b10000;

    logic [4:0] state_r;
    logic [4:0] next_s;
    logic [2:0] q_r;

    function automatic logic [4:0] bin_to_oh(input logic [2:0] b);
        logic [4:0] oh;
        case (b)
            S0:      oh = OH_S0;
            S1:      oh = OH_S1;
            S2:      oh = OH_S2;
            S3:      oh = OH_S3;
            S4:      oh = OH_S4;
            default: oh = OH_S0;
        endcase
        return oh;
    endfunction

    function automatic logic [2:0] oh_to_bin(input logic [4:0] oh);
        logic [2:0] b;
        case (oh)
            OH_S0:   b = S0;
            OH_S1:   b = S1;
            OH_S2:   b = S2;
            OH_S3:   b = S3;
            OH_S4:   b = S4;
            default: b = S0;
        endcase
        return b;
    endfunction

    // Next one-hot state; any corrupted pattern recovers to S0.
    always_comb begin
        next_s = OH_S0;
        case (state_r)
            OH_S0:   next_s = DIR ? OH_S4 : OH_S1;
            OH_S1:   next_s = DIR ? OH_S0 : OH_S2;
            OH_S2:   next_s = DIR ? OH_S1 : OH_S3;
            OH_S3:   next_s = DIR ? OH_S2 : OH_S4;
            OH_S4:   next_s = DIR ? OH_S3 : OH_S0;
            default: next_s = OH_S0;
        endcase
    end

    // State and q registered together from the next state so q aligns with the binary build.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= bin_to_oh(RST_IDX);
            q_r     <= RST_IDX;
        end else begin
            state_r <= next_s;
            q_r     <= oh_to_bin(next_s);
        end
    end

    assign q = q_r;

    mod_5_fsm_chk u_chk (
        .clk   (clk),
        .rst   (rst),
        .state (state_r)
    );
`else
    logic [2:0] state_r;
    state_t     next_s;

    // Next binary state; encodings 5..7 return to S0 regardless of DIR.
    always_comb begin
        next_s = S0;
        case (state_r)
            S0:      next_s = DIR ? S4 : S1;
            S1:      next_s = DIR ? S0 : S2;
            S2:      next_s = DIR ? S1 : S3;
            S3:      next_s = DIR ? S2 : S4;
            S4:      next_s = DIR ? S3 : S0;
            default: next_s = S0;
        endcase
    end

    // State register; reset wins over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RST_IDX;
        end else begin
            state_r <= next_s;
        end
    end

    assign q = state_r;
`endif

endmodule

// File: tb/tb_mod_5_fsm.sv
// Scoreboard bench for mod_5_fsm: three instances (up/reset 0, down/reset 2, up/illegal reset 7).
`timescale 1ns/1ps
module tb_mod_5_fsm;

    logic       clk;
    logic       rst;
    logic [2:0] q0;
    logic [2:0] q1;
    logic [2:0] q2;

    logic [2:0] exp0[$];
    logic [2:0] exp1[$];
    logic [2:0] exp2[$];

    int checks;
    int fails;

    mod_5_fsm #(.RST_STATE(0), .DIR(1'b0)) dut0 (.clk(clk), .rst(rst), .q(q0));
    mod_5_fsm #(.RST_STATE(2), .DIR(1'b1)) dut1 (.clk(clk), .rst(rst), .q(q1));
    mod_5_fsm #(.RST_STATE(7), .DIR(1'b0)) dut2 (.clk(clk), .rst(rst), .q(q2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: after each edge, compare every instance whose expectation is pending.
    always @(posedge clk) begin
        #1;
        if (exp0.size() > 0) check("q0_up_rst0", q0, exp0.pop_front());
        if (exp1.size() > 0) check("q1_down_rst2", q1, exp1.pop_front());
        if (exp2.size() > 0) check("q2_up_rst7", q2, exp2.pop_front());
    end

    task automatic step(input logic r, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        @(negedge clk);
        rst = r;
        exp0.push_back(a);
        exp1.push_back(b);
        exp2.push_back(c);
    endtask

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;

        // Reset edge, then 23 free-running edges (covers reset sequence, DIR=1 trace, long run).
        step(1'b1, 3'd0, 3'd2, 3'd0);
        for (int i = 1; i <= 23; i++) begin
            step(1'b0, 3'(i % 5), 3'((7 - (i % 5)) % 5), 3'(i % 5));
        end

        // dut0 now at 3: single-edge reset, then count, then reset held for 3 edges.
        step(1'b1, 3'd0, 3'd2, 3'd0);
        step(1'b0, 3'd1, 3'd1, 3'd1);
        step(1'b1, 3'd0, 3'd2, 3'd0);
        step(1'b1, 3'd0, 3'd2, 3'd0);
        step(1'b1, 3'd0, 3'd2, 3'd0);
        step(1'b0, 3'd1, 3'd1, 3'd1);
        step(1'b0, 3'd2, 3'd0, 3'd2);

`ifndef MOD5_FSM_ONEHOT_EN
        // Force dut0 into illegal encoding 6; the next edge must land on S0.
        @(negedge clk);
        rst = 1'b0;
        force dut0.state_r = 3'd6;
        #1;
        release dut0.state_r;
        exp0.push_back(3'd0);
        exp1.push_back(3'd4);
        exp2.push_back(3'd3);
        step(1'b0, 3'd1, 3'd3, 3'd4);
        step(1'b0, 3'd2, 3'd2, 3'd0);
`else
        step(1'b0, 3'd3, 3'd4, 3'd3);
        step(1'b0, 3'd4, 3'd3, 3'd4);
        step(1'b0, 3'd0, 3'd2, 3'd0);
`endif

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ((exp0.size() + exp1.size() + exp2.size()) != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0",
                     exp0.size() + exp1.size() + exp2.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mod_5_fsm.md
Name: mod_5_fsm

Overview:
- Free-running modulo-5 counter built as an explicit five-state Moore state machine.
- Each rising clock edge advances one state; the 3-bit output is the binary index of the current state, 0 through 4.
- Used as a small cycle-phase generator and divide-by-5 sequencer in sequential datapaths.
- Only a clock and a reset are inputs; there are no enable or load controls.

Parameters:
- RST_STATE, 0: state index loaded on reset. Legal range 0..4; any other value is treated as 0.
- DIR, 0: count direction. 0 = up (0→1→2→3→4→0). 1 = down (0→4→3→2→1→0).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous to clk, active-high.
- q    output 3  current state index, binary 3'b000..3'b100, driven directly from the state register.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- States S0..S4 are encoded as q = 0..4. q is a pure Moore output with no combinational path from any input.
- Reset:
  - On a rising clk edge with rst=1, the state becomes RST_STATE (default S0, q=3'b000).
  - rst has no effect between edges. q keeps its prior value until the first edge that samples rst=1.
  - Before the first reset edge, q is undefined in simulation (X allowed).
- Transitions (rst=0, DIR=0): S0→S1→S2→S3→S4→S0, one step per rising edge.
- Transitions (rst=0, DIR=1): S0→S4→S3→S2→S1→S0.
- Latency: q changes exactly one edge after the state decision. The first edge after rst deasserts moves from RST_STATE to its successor.
- Period: exactly 5 clock cycles. q holds each value for one full cycle.
- Wrap-around: after S4 the next state is S0 with no extra cycle (up). After S0 the next state is S4 (down).
- Illegal encodings 5, 6 and 7 are unreachable in normal operation. If one is forced, the next edge goes to S0 regardless of DIR. The FSM must never lock up.
- Reset mid-count: rst=1 at any state on any edge forces RST_STATE on that same edge. rst held high keeps q at RST_STATE on every edge.
- Reset and count coincide on one edge: reset wins.
- State register is 3 bits with a fully specified next-state case including a default branch. No latches.

Optional Feature:
- Macro: MOD5_FSM_ONEHOT_EN
- Defined:
  - State is held in a 5-bit one-hot register internally; q is produced by a registered one-hot-to-binary encode.
  - q timing and values are identical to the binary build.
  - Any non-one-hot pattern (zero or multiple bits set) recovers to one-hot S0 on the next edge.
  - Simulation-only $error fires whenever the state is not one-hot.
- Undefined:
  - The 3-bit binary state register is q itself; no internal check logic.

Test Plan:
- Reset: clk period 10, rst=1 for the first edge then 0 → q=0 after the reset edge, then 1,2,3,4,0 on the next 5 edges (50 time units).
- Long run: rst=0 for 20 edges after reset → q repeats 0,1,2,3,4 exactly 4 times, never exceeds 4, each value lasts 1 cycle.
- Mid-count reset: assert rst for one edge while q=3 → q=0 on that edge, then 1 on the following edge; rst held high for 3 edges → q stays 0.
- Illegal recovery: force the state to 6, release → q=0 after the next edge, then the normal sequence resumes.
- DIR=1, RST_STATE=2: reset then 6 edges → q sequence 2,1,0,4,3,2,1.
- With MOD5_FSM_ONEHOT_EN: repeat the reset and long-run scenarios → q trace cycle-identical to the binary build, and no $error is reported.
